// File: rtl/gpio_master_pkg.sv
// Shared types and constants for the GPIO bus master.
package gpio_master_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_READ  = 2'd1,
      OP_RMW   = 2'd2,
      OP_POLL  = 2'd3
   } op_e;

   localparam logic [1:0] GPIO_GPI1 = 2'd0;
   localparam logic [1:0] GPIO_GPI2 = 2'd1;
   localparam logic [1:0] GPIO_GPO1 = 2'd2;
   localparam logic [1:0] GPIO_GPO2 = 2'd3;

   typedef enum logic [1:0] {
      StIdle,
      StRd,
      StWr,
      StResp
   } state_e;

   // Writes to the input registers would be silently dropped by the peripheral.
   function automatic logic cmd_illegal(input op_e op, input logic [1:0] addr);
      return ((op == OP_WRITE) || (op == OP_RMW)) && (addr < GPIO_GPO1);
   endfunction

endpackage

// File: rtl/gpio_master_poll_counter.sv
// Counts completed poll reads and flags the read that reaches the limit.
module poll_counter #(
   parameter int unsigned LIM_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [LIM_W-1:0] limit,
   output logic             hit
);

   logic [LIM_W-1:0] cnt_q;
   logic [LIM_W-1:0] eff_limit;

   // A limit of zero still allows a single read.
   assign eff_limit = (limit == '0) ? LIM_W'(1) : limit;

   // hit refers to the read in progress, i.e. read number cnt_q + 1.
   assign hit = ({1'b0, cnt_q} + (LIM_W + 1)'(1)) >= {1'b0, eff_limit};

   // Completed-read counter; only incremented below the limit, so it cannot wrap.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (inc) begin
         cnt_q <= cnt_q + LIM_W'(1);
      end
   end

endmodule

// File: rtl/gpio_master.sv
// Command-driven initiator for the two-register GPIO peripheral bus.
module gpio_master
   import gpio_master_pkg::*;
#(
   parameter int unsigned DW    = 32,
   parameter int unsigned LIM_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [1:0]       cmd_addr,
   input  logic [DW-1:0]    cmd_data,
   input  logic [DW-1:0]    cmd_mask,
   input  logic [LIM_W-1:0] cmd_limit,
   output logic             bus_we,
   output logic [1:0]       bus_addr,
   output logic [DW-1:0]    bus_wd,
   input  logic [DW-1:0]    bus_rd,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DW-1:0]    rsp_data,
   output logic             rsp_err
);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [1:0]       addr_q, addr_d;
   logic [DW-1:0]    data_q, data_d;
   logic [DW-1:0]    mask_q, mask_d;
   logic [DW-1:0]    wval_q, wval_d;
   logic [DW-1:0]    rsp_data_q, rsp_data_d;
   logic [LIM_W-1:0] limit_q, limit_d;
   logic             rsp_err_q, rsp_err_d;
   logic             cnt_clr, cnt_inc, cnt_hit;
   logic             poll_match;
   logic [DW-1:0]    rmw_val;

   assign rmw_val    = (bus_rd & ~mask_q) | (data_q & mask_q);
   assign poll_match = (bus_rd & mask_q) == (data_q & mask_q);

   assign rsp_data = rsp_data_q;
   assign rsp_err  = rsp_err_q;

   poll_counter #(
      .LIM_W(LIM_W)
   ) u_poll_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .limit(limit_q),
      .hit  (cnt_hit)
   );

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         op_q       <= OP_WRITE;
         addr_q     <= '0;
         data_q     <= '0;
         mask_q     <= '0;
         limit_q    <= '0;
         wval_q     <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         mask_q     <= mask_d;
         limit_q    <= limit_d;
         wval_q     <= wval_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // Next-state, bus drive and handshake decode.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      data_d     = data_q;
      mask_d     = mask_q;
      limit_d    = limit_q;
      wval_d     = wval_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      cmd_ready  = 1'b0;
      rsp_valid  = 1'b0;
      bus_we     = 1'b0;
      bus_addr   = GPIO_GPI1;
      bus_wd     = '0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;

      unique case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_d    = op_e'(cmd_op);
               addr_d  = cmd_addr;
               data_d  = cmd_data;
               mask_d  = cmd_mask;
               limit_d = cmd_limit;
               wval_d  = cmd_data;
               cnt_clr = 1'b1;
               if (cmd_illegal(op_e'(cmd_op), cmd_addr)) begin
                  rsp_data_d = '0;
                  rsp_err_d  = 1'b1;
                  state_d    = StResp;
               end else if (op_e'(cmd_op) == OP_WRITE) begin
                  state_d = StWr;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd: begin
            bus_addr = addr_q;
            unique case (op_q)
               OP_READ: begin
                  rsp_data_d = bus_rd;
                  rsp_err_d  = 1'b0;
                  state_d    = StResp;
               end
               OP_RMW: begin
                  wval_d  = rmw_val;
                  state_d = StWr;
               end
               OP_POLL: begin
                  rsp_data_d = bus_rd;
                  if (poll_match) begin
                     rsp_err_d = 1'b0;
                     state_d   = StResp;
                  end else if (cnt_hit) begin
                     rsp_err_d = 1'b1;
                     state_d   = StResp;
                  end else begin
                     cnt_inc = 1'b1;
                  end
               end
               default: state_d = StIdle;
            endcase
         end
         StWr: begin
            bus_we     = 1'b1;
            bus_addr   = addr_q;
            bus_wd     = wval_q;
            rsp_data_d = wval_q;
            rsp_err_d  = 1'b0;
            state_d    = StResp;
         end
         StResp: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_gpio_master.sv
// Self-checking bench for gpio_master with a behavioural peripheral and command model.
module tb_gpio_master;
   import gpio_master_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_op, cmd_addr;
   logic [31:0] cmd_data, cmd_mask;
   logic [15:0] cmd_limit;
   logic        bus_we;
   logic [1:0]  bus_addr;
   logic [31:0] bus_wd, bus_rd;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Peripheral registers and gpi1 change schedule (cycle 1 = first cycle after accept).
   logic [31:0] gpi1, gpi2, gpo1, gpo2;
   logic [31:0] gpi1_old, gpi1_new;
   int          gpi1_sw;
   logic [31:0] ref_gpo[2];

   typedef struct {
      logic        got;
      logic [31:0] data;
      logic        err;
      int          lat;
      int          we_n;
      logic [31:0] wd;
      logic [1:0]  waddr;
      logic [1:0]  rd_addr;
      longint      t_acc;
   } obs_t;

   always #5 clk = ~clk;

   gpio_master #(
      .DW(32),
      .LIM_W(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op   (cmd_op),
      .cmd_addr (cmd_addr),
      .cmd_data (cmd_data),
      .cmd_mask (cmd_mask),
      .cmd_limit(cmd_limit),
      .bus_we   (bus_we),
      .bus_addr (bus_addr),
      .bus_wd   (bus_wd),
      .bus_rd   (bus_rd),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data (rsp_data),
      .rsp_err  (rsp_err)
   );

   always_comb begin
      case (bus_addr)
         2'd0:    bus_rd = gpi1;
         2'd1:    bus_rd = gpi2;
         2'd2:    bus_rd = gpo1;
         default: bus_rd = gpo2;
      endcase
   end

   always @(posedge clk) begin
      if (bus_we && bus_addr == 2'd2) gpo1 <= bus_wd;
      if (bus_we && bus_addr == 2'd3) gpo2 <= bus_wd;
   end

   function automatic logic [31:0] model_reg(input logic [1:0] a, input int cyc);
      case (a)
         2'd0:    return (gpi1_sw != 0 && cyc >= gpi1_sw) ? gpi1_new : gpi1_old;
         2'd1:    return gpi2;
         2'd2:    return ref_gpo[0];
         default: return ref_gpo[1];
      endcase
   endfunction

   // Expected response, latency and write count of one command; updates the gpo model.
   task automatic model_cmd(input logic [1:0] op, input logic [1:0] addr,
                            input logic [31:0] data, input logic [31:0] mask,
                            input logic [15:0] limit, output logic [31:0] e_data,
                            output logic e_err, output int e_lat, output int e_we);
      int          eff;
      logic [31:0] v;
      e_err = 1'b0;
      e_we  = 0;
      if ((op == OP_WRITE || op == OP_RMW) && addr < 2) begin
         e_data = 32'h0; e_err = 1'b1; e_lat = 1;
      end else if (op == OP_WRITE) begin
         e_data = data; e_lat = 2; e_we = 1;
         ref_gpo[addr - 2] = data;
      end else if (op == OP_READ) begin
         e_data = model_reg(addr, 1); e_lat = 2;
      end else if (op == OP_RMW) begin
         v      = model_reg(addr, 1);
         e_data = (v & ~mask) | (data & mask); e_lat = 3; e_we = 1;
         ref_gpo[addr - 2] = e_data;
      end else begin
         eff    = (limit == 0) ? 1 : int'(limit);
         e_data = 32'h0; e_lat = 0;
         for (int i = 1; i <= eff; i++) begin
            v = model_reg(addr, i);
            e_data = v;
            e_lat  = i + 1;
            if ((v & mask) == (data & mask)) break;
            if (i == eff) e_err = 1'b1;
         end
      end
   endtask

   // Issue one command from an idle cycle and observe it through the handshake.
   task automatic run_cmd(input logic [1:0] op, input logic [1:0] addr,
                          input logic [31:0] data, input logic [31:0] mask,
                          input logic [15:0] limit, output obs_t o);
      o.got = 1'b0; o.data = '0; o.err = 1'b0; o.lat = 0; o.we_n = 0;
      o.wd = '0; o.waddr = '0; o.rd_addr = '0;
      gpi1      = gpi1_old;
      cmd_op    = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask; cmd_limit = limit;
      cmd_valid = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk);
      o.t_acc = longint'($time);
      #1;
      cmd_valid = 1'b0;
      o.lat = 1;
      while (o.lat < 1000) begin
         if (gpi1_sw != 0 && o.lat >= gpi1_sw) gpi1 = gpi1_new;
         if (rsp_valid) begin
            o.got = 1'b1; o.data = rsp_data; o.err = rsp_err;
            break;
         end
         if (bus_we) begin
            o.we_n++; o.wd = bus_wd; o.waddr = bus_addr;
         end else begin
            o.rd_addr = bus_addr;
         end
         @(posedge clk); #1;
         o.lat++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0; cmd_limit = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset cmd_ready got %b want 1", cmd_ready); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid got %b want 0", rsp_valid); end
      n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset rsp_data got %h want 0", rsp_data); end
      n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset rsp_err got %b want 0", rsp_err); end
      n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL reset bus_we got %b want 0", bus_we); end
      n_checks++; if (bus_addr !== 2'd0) begin n_fail++; $display("FAIL reset bus_addr got %h want 0", bus_addr); end
      n_checks++; if (bus_wd !== 32'h0) begin n_fail++; $display("FAIL reset bus_wd got %h want 0", bus_wd); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      obs_t o;
      run_cmd(OP_WRITE, 2'd2, 32'hDEADBEEF, 32'h0, 16'd0, o);
      ref_gpo[0] = 32'hDEADBEEF;
      n_checks++; if (o.got !== 1'b1 || o.lat != 2) begin n_fail++; $display("FAIL write latency got %0d want 2", o.lat); end
      n_checks++; if (o.we_n != 1) begin n_fail++; $display("FAIL write we_cycles got %0d want 1", o.we_n); end
      n_checks++; if (o.wd !== 32'hDEADBEEF || o.waddr !== 2'd2) begin n_fail++; $display("FAIL write bus got %h@%0d want deadbeef@2", o.wd, o.waddr); end
      n_checks++; if (o.data !== 32'hDEADBEEF || o.err !== 1'b0) begin n_fail++; $display("FAIL write rsp got %h/%b want deadbeef/0", o.data, o.err); end
      n_checks++; if (gpo1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write gpo1 got %h want deadbeef", gpo1); end
   endtask

   task automatic test_rmw();
      obs_t o;
      run_cmd(OP_WRITE, 2'd3, 32'hFFFF0000, 32'h0, 16'd0, o);
      run_cmd(OP_RMW, 2'd3, 32'h000000AA, 32'h000000FF, 16'd0, o);
      ref_gpo[1] = 32'hFFFF00AA;
      n_checks++; if (o.got !== 1'b1 || o.lat != 3) begin n_fail++; $display("FAIL rmw latency got %0d want 3", o.lat); end
      n_checks++; if (o.data !== 32'hFFFF00AA || o.err !== 1'b0) begin n_fail++; $display("FAIL rmw rsp got %h/%b want ffff00aa/0", o.data, o.err); end
      n_checks++; if (o.we_n != 1 || o.rd_addr !== 2'd3) begin n_fail++; $display("FAIL rmw bus got we=%0d rd_addr=%0d want 1/3", o.we_n, o.rd_addr); end
      n_checks++; if (gpo2 !== 32'hFFFF00AA) begin n_fail++; $display("FAIL rmw gpo2 got %h want ffff00aa", gpo2); end
   endtask

   task automatic test_illegal();
      obs_t o;
      run_cmd(OP_WRITE, 2'd0, 32'h12345678, 32'h0, 16'd0, o);
      n_checks++; if (o.got !== 1'b1 || o.lat != 1) begin n_fail++; $display("FAIL illegal_wr latency got %0d want 1", o.lat); end
      n_checks++; if (o.data !== 32'h0 || o.err !== 1'b1) begin n_fail++; $display("FAIL illegal_wr rsp got %h/%b want 0/1", o.data, o.err); end
      n_checks++; if (o.we_n != 0) begin n_fail++; $display("FAIL illegal_wr we_cycles got %0d want 0", o.we_n); end
      run_cmd(OP_RMW, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'd0, o);
      n_checks++; if (o.lat != 1 || o.err !== 1'b1 || o.we_n != 0) begin n_fail++; $display("FAIL illegal_rmw got lat=%0d err=%b we=%0d want 1/1/0", o.lat, o.err, o.we_n); end
   endtask

   task automatic test_poll();
      obs_t o;
      gpi1_old = 32'h0; gpi1_new = 32'h5; gpi1_sw = 4;
      run_cmd(OP_POLL, 2'd0, 32'h5, 32'hF, 16'd10, o);
      n_checks++; if (o.got !== 1'b1 || o.lat != 5) begin n_fail++; $display("FAIL poll_match latency got %0d want 5", o.lat); end
      n_checks++; if (o.data !== 32'h5 || o.err !== 1'b0) begin n_fail++; $display("FAIL poll_match rsp got %h/%b want 5/0", o.data, o.err); end
      gpi1_old = 32'h0; gpi1_sw = 0;
      run_cmd(OP_POLL, 2'd0, 32'h5, 32'hF, 16'd0, o);
      n_checks++; if (o.got !== 1'b1 || o.lat != 2) begin n_fail++; $display("FAIL poll_lim0 latency got %0d want 2", o.lat); end
      n_checks++; if (o.data !== 32'h0 || o.err !== 1'b1) begin n_fail++; $display("FAIL poll_lim0 rsp got %h/%b want 0/1", o.data, o.err); end
      run_cmd(OP_POLL, 2'd0, 32'h5, 32'hF, 16'd3, o);
      n_checks++; if (o.lat != 4 || o.err !== 1'b1) begin n_fail++; $display("FAIL poll_lim3 got lat=%0d err=%b want 4/1", o.lat, o.err); end
   endtask

   task automatic test_backpressure();
      int          w;
      logic [31:0] want;
      want = ref_gpo[0];
      cmd_op = OP_READ; cmd_addr = 2'd2; cmd_data = '0; cmd_mask = '0; cmd_limit = '0;
      cmd_valid = 1'b1; rsp_ready = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      w = 0;
      while (!rsp_valid && w < 20) begin @(posedge clk); #1; w++; end
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp timeout rsp_valid got %b want 1", rsp_valid); end
      for (int s = 0; s < 5; s++) begin
         @(posedge clk); #1;
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== want || cmd_ready !== 1'b0 ||
             bus_we !== 1'b0 || bus_addr !== 2'd0 || bus_wd !== 32'h0) begin
            n_fail++;
            $display("FAIL bp stall%0d got v=%b d=%h rdy=%b we=%b a=%0d wd=%h want 1/%h/0/0/0/0",
                     s, rsp_valid, rsp_data, cmd_ready, bus_we, bus_addr, bus_wd, want);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp release got v=%b rdy=%b want 0/1", rsp_valid, cmd_ready); end
   endtask

   task automatic test_reset_in_wr();
      int seen;
      cmd_op = OP_WRITE; cmd_addr = 2'd3; cmd_data = 32'h12345678; cmd_mask = '0; cmd_limit = '0;
      cmd_valid = 1'b1; rsp_ready = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n_checks++; if (bus_we !== 1'b1) begin n_fail++; $display("FAIL rst_wr pre bus_we got %b want 1", bus_we); end
      rst = 1'b1;
      @(posedge clk); #1;
      // The peripheral still saw the write strobe on the reset edge.
      ref_gpo[1] = 32'h12345678;
      n_checks++; if (bus_we !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wr post got we=%b rdy=%b v=%b want 0/1/0", bus_we, cmd_ready, rsp_valid); end
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (rsp_valid) seen++; end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_wr response cycles got %0d want 0", seen); end
   endtask

   task automatic test_back_to_back();
      obs_t o1, o2, o3;
      run_cmd(OP_WRITE, 2'd2, 32'h11111111, 32'h0, 16'd0, o1);
      run_cmd(OP_WRITE, 2'd3, 32'h22222222, 32'h0, 16'd0, o2);
      run_cmd(OP_WRITE, 2'd2, 32'h33333333, 32'h0, 16'd0, o3);
      ref_gpo[0] = 32'h33333333; ref_gpo[1] = 32'h22222222;
      n_checks++; if (o2.t_acc - o1.t_acc != 30 || o3.t_acc - o2.t_acc != 30) begin n_fail++; $display("FAIL b2b accept spacing got %0d/%0d want 30/30", o2.t_acc - o1.t_acc, o3.t_acc - o2.t_acc); end
      n_checks++; if (gpo1 !== 32'h33333333 || gpo2 !== 32'h22222222) begin n_fail++; $display("FAIL b2b gpo got %h/%h want 33333333/22222222", gpo1, gpo2); end
   endtask

   task automatic test_random();
      obs_t        o;
      logic [1:0]  op, addr;
      logic [31:0] data, mask, e_data;
      logic [15:0] limit;
      logic        e_err;
      int          e_lat, e_we;
      for (int n = 0; n < 40; n++) begin
         op       = 2'($urandom_range(0, 3));
         addr     = 2'($urandom_range(0, 3));
         data     = $urandom;
         mask     = (op == OP_POLL) ? ($urandom & 32'h0F) : $urandom;
         limit    = 16'($urandom_range(0, 5));
         gpi2     = $urandom;
         gpi1_old = $urandom;
         gpi1_new = ($urandom & ~mask) | (data & mask);
         gpi1_sw  = $urandom_range(0, 6);
         model_cmd(op, addr, data, mask, limit, e_data, e_err, e_lat, e_we);
         run_cmd(op, addr, data, mask, limit, o);
         n_checks++; if (o.got !== 1'b1 || o.lat != e_lat) begin n_fail++; $display("FAIL rnd%0d op%0d latency got %0d want %0d", n, op, o.lat, e_lat); end
         n_checks++; if (o.data !== e_data || o.err !== e_err) begin n_fail++; $display("FAIL rnd%0d op%0d rsp got %h/%b want %h/%b", n, op, o.data, o.err, e_data, e_err); end
         n_checks++; if (o.we_n != e_we) begin n_fail++; $display("FAIL rnd%0d op%0d we_cycles got %0d want %0d", n, op, o.we_n, e_we); end
         n_checks++; if (gpo1 !== ref_gpo[0] || gpo2 !== ref_gpo[1]) begin n_fail++; $display("FAIL rnd%0d gpo got %h/%h want %h/%h", n, gpo1, gpo2, ref_gpo[0], ref_gpo[1]); end
      end
   endtask

   initial begin
      gpi1 = '0; gpi2 = 32'hA5A5A5A5; gpo1 = '0; gpo2 = '0;
      gpi1_old = '0; gpi1_new = '0; gpi1_sw = 0;
      ref_gpo[0] = '0; ref_gpo[1] = '0;
      test_reset();
      test_write();
      test_rmw();
      test_illegal();
      test_poll();
      test_backpressure();
      test_reset_in_wr();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gpio_master.md
# gpio_master

Bus initiator that drives the two-register GPIO peripheral's `we`/`addr`/`wd`/`rd` port on behalf of a command source. It accepts one command at a time over a valid/ready handshake and executes it as a single write, a single read, a read-modify-write, or a bounded poll. It returns one response per command over a second valid/ready handshake. It sits between a control FSM (or CPU-side glue) and the GPIO peripheral.

## Interface
- `DW`, 32: data width of the bus and command fields.
- `LIM_W`, 16: width of the poll read-limit field.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: master can accept a command.
- `cmd_op` in 2: operation, one of `OP_WRITE`, `OP_READ`, `OP_RMW`, `OP_POLL`.
- `cmd_addr` in 2: peripheral address. 0 = gpi1, 1 = gpi2, 2 = gpo1, 3 = gpo2.
- `cmd_data` in DW: write data, RMW insert value, or poll match value.
- `cmd_mask` in DW: RMW field mask, or poll compare mask.
- `cmd_limit` in LIM_W: maximum number of poll reads; 0 is treated as 1.
- `bus_we` out 1: peripheral write enable.
- `bus_addr` out 2: peripheral address.
- `bus_wd` out DW: peripheral write data.
- `bus_rd` in DW: peripheral read data, combinational from `bus_addr`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumer ready.
- `rsp_data` out DW: result data.
- `rsp_err` out 1: illegal command or poll timeout.

## Operation
- States: `IDLE`, `RD`, `WR`, `RESP`.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, register all `cmd_*` fields.
  - Next state: WRITE → `WR`; READ, RMW, POLL → `RD`.
  - Illegal command → `RESP` with `rsp_err`=1, `rsp_data`=0, and no bus traffic.
- **Illegal command:** WRITE or RMW with `cmd_addr` < 2. These are the input registers, and the peripheral ignores writes to them.
- **RD**
  - Drive `bus_addr`=addr and `bus_we`=0.
  - Sample `bus_rd` into the data register at the end of the cycle.
- **READ:** `RD` → `RESP`, with `rsp_data` = sampled value.
- **RMW**
  - `RD` → `WR`.
  - The `WR` write value is `(rd & ~mask) | (data & mask)`.
  - `rsp_data` = the written value.
- **POLL**
  - Stay in `RD`, one read per cycle, incrementing the read counter.
  - Match when `(bus_rd & mask) == (data & mask)`: go to `RESP` with `rsp_err`=0.
  - If the read just completed is read number `limit` and it did not match: go to `RESP` with `rsp_err`=1.
  - In both cases `rsp_data` = the last sampled value.
- **WR**
  - Drive `bus_we`=1, `bus_addr`=addr, `bus_wd`=write value for exactly one cycle.
  - Next state is `RESP`.
  - WRITE returns `rsp_data`=`cmd_data`.
- **RESP**
  - `rsp_valid`=1.
  - `rsp_data` and `rsp_err` are held stable until `rsp_ready`.
  - On handshake → `IDLE`.
- **Outside RD/WR:** `bus_we`=0, `bus_addr`=0, `bus_wd`=0.
- **Reset**
  - State goes to `IDLE`. All registers and outputs go to 0 except `cmd_ready`=1.
  - A reset during any state aborts the command with no response.
  - `bus_we` is low from the reset edge onward.

## Timing
- `cmd_ready` is a combinational decode of `state==IDLE`. It is 0 in every other state, so there is no command overlap.
- Cycle counts are measured from the accept edge to the first cycle `rsp_valid`=1:
  - WRITE: 2 (`WR`, `RESP`).
  - READ: 2.
  - RMW: 3.
  - Illegal: 1.
  - POLL: N+1 for N reads, where N ≤ max(`limit`, 1).
- The peripheral register updates on the edge that ends the `WR` cycle.
- After a response handshake, the next command can be accepted in the following cycle. Peak throughput is one WRITE per 3 cycles.
- `rsp_ready` held 0 stalls the master in `RESP` indefinitely. The bus stays idle during the stall.
- The poll counter is LIM_W bits wide, compared with ≥ against the effective limit, so it never wraps.

## Structure
- Package `gpio_master_pkg` contains:
  - the op enum (`OP_WRITE`=0, `OP_READ`=1, `OP_RMW`=2, `OP_POLL`=3);
  - the address constants `GPIO_GPI1`=0, `GPIO_GPI2`=1, `GPIO_GPO1`=2, `GPIO_GPO2`=3;
  - the state enum.
- One sub-module, `poll_counter`. It has clear, increment, and limit inputs and a `hit` output, and implements the limit-0-as-1 rule.
- The FSM, datapath registers, and RMW merge logic live in `gpio_master`.

## Test plan
- **WRITE:** addr 2, data 0xDEADBEEF → `bus_we`=1 for exactly one cycle with `bus_wd`=0xDEADBEEF; gpo1 reads back 0xDEADBEEF; response arrives 2 cycles after accept with `rsp_err`=0.
- **RMW:** gpo2=0xFFFF0000, data 0x0000_00AA, mask 0x0000_00FF → gpo2=0xFFFF00AA; `rsp_data`=0xFFFF00AA.
- **Illegal WRITE:** addr 0 → `bus_we` never asserts; response 1 cycle after accept with `rsp_err`=1 and `rsp_data`=0.
- **POLL match:** gpi1 changes to 0x5 after 3 cycles; mask 0xF, data 0x5, limit 10 → `rsp_err`=0, `rsp_data`=0x5 after 4 reads. **POLL timeout:** limit 0 with no match → exactly 1 read, then `rsp_err`=1.
- **Back-pressure:** hold `rsp_ready`=0 for 5 cycles → `rsp_data` stable, `cmd_ready`=0, bus idle. **Reset in `WR`:** `bus_we` low after the edge, no response, `cmd_ready`=1.
